// File: rtl/ex_div_pkg.sv
// Shared constants and types for the EX-stage RV32M divide unit.
package ex_div_pkg;

  localparam int XLEN    = 32;
  localparam int CNT_W   = $clog2(XLEN);

  // R-type M-extension encoding fields
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 codes for the divide group
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) sitting in the EX stage.
// It stalls the front of the pipeline while iterating and pulses valid_o
// for one cycle with the result, rd address and write enable.
//
// Handshake: the ID/EX register holds the div instruction stable while
// stall_o is high. valid_o is a single-cycle pulse with no back-pressure;
// the writeback mux must take result_o/rd_addr_o/reg_wen_o in that cycle.
// flush_i kills any in-flight operation and masks the pulse in that cycle.
module ex_div
  import ex_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  div_state_e        state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Decode of the instruction held in ID/EX
  logic [2:0]      funct3;
  logic            is_div, is_signed, start;
  logic            div_zero, sgn_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b;

  assign funct3    = inst_i[14:12];
  assign is_div    = (inst_i[6:0] == INST_TYPE_R_M) && (inst_i[31:25] == FUNCT7_MULDIV)
                     && funct3[2];
  assign is_signed = ~funct3[0];
  assign start     = (state_q == ST_IDLE) && is_div && !flush_i;
  assign div_zero  = (op2_i == '0);
  assign sgn_ovf   = is_signed && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
  assign special   = div_zero || sgn_ovf;
  assign abs_a     = (is_signed && op1_i[XLEN-1]) ? (~op1_i + 1'b1) : op1_i;
  assign abs_b     = (is_signed && op2_i[XLEN-1]) ? (~op2_i + 1'b1) : op2_i;

  // One restoring step. The shifted partial remainder can need 33 bits when
  // the divisor is above 2^31, so the compare is done one bit wider.
  logic [XLEN:0]   partial;
  logic [XLEN+1:0] diff;
  logic            ge;

  assign partial = {rem_q, dvd_q[XLEN-1]};
  assign diff    = {1'b0, partial} - {2'b00, dvs_q};
  assign ge      = ~diff[XLEN+1];

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rd_d       = rd_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_rem_d = funct3[1];
          rd_d     = rd_addr_i;
          if (special) begin
            // Architected results are loaded directly, no sign fix-up
            state_d    = ST_DONE;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            dvd_d      = '0;
            dvs_d      = '0;
            quot_d     = div_zero ? '1 : 32'h8000_0000;
            rem_d      = div_zero ? op1_i : '0;
          end else begin
            state_d    = ST_BUSY;
            neg_quot_d = is_signed && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
            neg_rem_d  = is_signed && op1_i[XLEN-1];
            dvd_d      = abs_a;
            dvs_d      = abs_b;
            rem_d      = '0;
            quot_d     = '0;
            cnt_d      = '0;
          end
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d  = ge ? diff[XLEN-1:0] : partial[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], ge};
          dvd_d  = {dvd_q[XLEN-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rd_q       <= rd_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs: result fields are zero except in an unflushed DONE cycle
  logic [XLEN-1:0] final_res;

  always_comb begin
    final_res = '0;
    if (is_rem_q) final_res = neg_rem_q  ? (~rem_q  + 1'b1) : rem_q;
    else          final_res = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
  end

  assign valid_o   = (state_q == ST_DONE) && !flush_i;
  assign reg_wen_o = valid_o;
  assign result_o  = valid_o ? final_res : '0;
  assign rd_addr_o = valid_o ? rd_q : '0;
  assign stall_o   = !flush_i && ((start && !special) || (state_q == ST_BUSY));

endmodule

// File: tb/tb_ex_div.sv
// Directed and randomized bench for the EX-stage divider.
module tb_ex_div;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i, op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        stall_o, valid_o, reg_wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int vectors     = 0;
  int miscompares = 0;

  ex_div dut (
    .clk       (clk),
    .rst       (rst),
    .inst_i    (inst_i),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o),
    .reg_wen_o (reg_wen_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Behavioural RV32M divide semantics
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return f3[1] ? r[31:0] : q[31:0];
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  // Driver: present one div, watch stall/valid, check result, retire it.
  // Entered and left at a negedge.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int          cyc    = 0;
    int          stalls = 0;
    bit          got    = 0;
    bit          spec;
    logic [31:0] exp;
    spec = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp  = ref_div(f3, a, b);
    inst_i = mk_inst(f3, rd); op1_i = a; op2_i = b; rd_addr_i = rd;
    while (!got && cyc < 40) begin
      #1;
      if (valid_o) begin
        got = 1;
        check("latency", 32'(cyc), spec ? 32'd1 : 32'd33);
        check("stall_cycles", 32'(stalls), spec ? 32'd0 : 32'd33);
        check("result", result_o, exp);
        check("rd_addr", {27'd0, rd_addr_o}, {27'd0, rd});
        check("reg_wen", {31'd0, reg_wen_o}, 32'd1);
        check("stall_in_done", {31'd0, stall_o}, 32'd0);
        inst_i = NOP;
      end else if (stall_o) begin
        stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    if (!got) check("valid_timeout", 32'd0, 32'd1);
    inst_i = NOP;
    #1;
    check("single_pulse", {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; inst_i = NOP; op1_i = '0; op2_i = '0; rd_addr_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_rd", {27'd0, rd_addr_o}, 32'd0);
    check("reset_wen", {31'd0, reg_wen_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // directed cases
    run_op(3'b101, 32'h64, 32'h7, 5'd5);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h2, 5'd6);
    run_op(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd7);
    run_op(3'b100, 32'h1234, 32'h0, 5'd8);
    run_op(3'b111, 32'h1234, 32'h0, 5'd9);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0, 5'd10);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run_op(3'b111, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd14);
    run_op(3'b101, 32'h1234, 32'h1, 5'd0);
    // back-to-back
    run_op(3'b101, 32'hFFFF_FFFF, 32'h10, 5'd1);
    run_op(3'b101, 32'h30, 32'h3, 5'd2);

    // flush at BUSY cycle 10: no result, stall drops, unit idles
    @(negedge clk);
    inst_i = mk_inst(3'b101, 5'd3); op1_i = 32'h1234; op2_i = 32'h3; rd_addr_i = 5'd3;
    repeat (11) @(negedge clk);
    #1;
    flush_i = 1'b1;
    #1;
    check("flush_busy_stall", {31'd0, stall_o}, 32'd0);
    check("flush_busy_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0; inst_i = NOP;
    #1;
    check("post_flush_stall", {31'd0, stall_o}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (valid_o || stall_o) seen = 1;
    end
    check("post_flush_quiet", {31'd0, seen}, 32'd0);

    // flush while a div is presented in IDLE: not accepted
    inst_i = mk_inst(3'b100, 5'd4); op1_i = 32'h99; op2_i = 32'h3; flush_i = 1'b1;
    #1;
    check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0; inst_i = NOP;
    #1;
    check("flush_idle_nostart", {31'd0, stall_o}, 32'd0);

    // flush in the DONE cycle masks the write
    @(negedge clk);
    inst_i = mk_inst(3'b100, 5'd9); op1_i = 32'h55; op2_i = 32'h0; rd_addr_i = 5'd9;
    @(negedge clk);
    inst_i = NOP; flush_i = 1'b1;
    #1;
    check("flush_done_valid", {31'd0, valid_o}, 32'd0);
    check("flush_done_wen", {31'd0, reg_wen_o}, 32'd0);
    check("flush_done_result", result_o, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_done_after", {31'd0, valid_o}, 32'd0);

    // asynchronous reset mid-BUSY
    @(negedge clk);
    inst_i = mk_inst(3'b100, 5'd17); op1_i = 32'hABCD; op2_i = 32'h13; rd_addr_i = 5'd17;
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b0; inst_i = NOP;
    #1;
    check("midreset_stall", {31'd0, stall_o}, 32'd0);
    check("midreset_valid", {31'd0, valid_o}, 32'd0);
    check("midreset_result", result_o, 32'd0);
    check("midreset_rd", {27'd0, rd_addr_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (valid_o || stall_o) seen = 1;
    end
    check("midreset_idle", {31'd0, seen}, 32'd0);
    @(negedge clk);
    run_op(3'b100, 32'hFFFF_FF00, 32'h7, 5'd18);

    // randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          sel;
      f3  = 3'($urandom_range(4, 7));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = b | 32'h8000_0000;
        default: ;
      endcase
      run_op(f3, a, b, 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
